regfile_sync: RTL and testbench

Parametrised successor to the 16x32 register memory used by the filter-processor datapath: a DATA_W x DEPTH register file with two registered read ports, one write port, optional write-to-read forwarding and a sequenced clear engine. It sits between the decode stage, which drives the read addresses, and the write-back stage, which drives the write port. It also exports three debug taps for the test harness.

---
 rtl/regfile_sync.sv | 116 +++++++++++
 tb/tb_regfile_sync.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sync.sv
// DATA_W x DEPTH register file: two registered read ports, one write port, sweeping clear engine.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a colliding read (write-first).
module regfile_sync #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int DBG_BASE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ra_en,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic              rb_en,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic [DATA_W-1:0] ra_data,
    output logic              ra_valid,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid,
    output logic [DATA_W-1:0] dbg0,
    output logic [DATA_W-1:0] dbg1,
    output logic [DATA_W-1:0] dbg2
);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_wr_ok;
    logic              w_ra_in;
    logic              w_rb_in;
    logic [DATA_W-1:0] w_ra_word;
    logic [DATA_W-1:0] w_rb_word;
    logic [DATA_W-1:0] w_ra_next;
    logic [DATA_W-1:0] w_rb_next;

    // a clr_req in IDLE pre-empts any access presented in the same cycle
    assign w_accept  = (r_state == ST_IDLE) && !clr_req;
    assign w_wr_ok   = w_accept && wr_en && ({1'b0, wr_addr} < LP_DEPTH);
    assign w_ra_in   = {1'b0, ra_addr} < LP_DEPTH;
    assign w_rb_in   = {1'b0, rb_addr} < LP_DEPTH;
    assign w_ra_word = w_ra_in ? r_mem[ra_addr] : '0;
    assign w_rb_word = w_rb_in ? r_mem[rb_addr] : '0;

`ifdef REGFILE_BYPASS_EN
    assign w_ra_next = (w_wr_ok && wr_addr == ra_addr) ? wr_data : w_ra_word;
    assign w_rb_next = (w_wr_ok && wr_addr == rb_addr) ? wr_data : w_rb_word;
`else
    assign w_ra_next = w_ra_word;
    assign w_rb_next = w_rb_word;
`endif

    assign dbg0 = r_mem[DBG_BASE];
    assign dbg1 = r_mem[DBG_BASE+1];
    assign dbg2 = r_mem[DBG_BASE+2];

    // storage has no reset of its own; the sweep zeroes it
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            busy      <= 1'b1;
            ra_data   <= '0;
            rb_data   <= '0;
            ra_valid  <= 1'b0;
            rb_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    ra_valid  <= 1'b0;
                    rb_valid  <= 1'b0;
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LP_LAST) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    if (clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_ptr <= '0;
                        busy      <= 1'b1;
                        ra_valid  <= 1'b0;
                        rb_valid  <= 1'b0;
                    end else begin
                        ra_valid <= ra_en;
                        rb_valid <= rb_en;
                        if (ra_en) ra_data <= w_ra_next;
                        if (rb_en) rb_data <= w_rb_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sync.sv
// Randomized bench for regfile_sync: 32x16 and 8x12 instances against an array model.
// Collision expectation follows REGFILE_BYPASS_EN.
module tb_regfile_sync;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: DATA_W=32, DEPTH=16
    logic        rst = 1'b1, ra_en = 1'b0, rb_en = 1'b0, wr_en = 1'b0, clr_req = 1'b0;
    logic [3:0]  ra_addr = '0, rb_addr = '0, wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy, ra_valid, rb_valid;
    logic [31:0] ra_data, rb_data, dbg0, dbg1, dbg2;

    // instance 1: DATA_W=8, DEPTH=12
    logic        s_rst = 1'b1, s_ra_en = 1'b0, s_rb_en = 1'b0, s_wr_en = 1'b0, s_clr_req = 1'b0;
    logic [3:0]  s_ra_addr = '0, s_rb_addr = '0, s_wr_addr = '0;
    logic [7:0]  s_wr_data = '0;
    logic        s_busy, s_ra_valid, s_rb_valid;
    logic [7:0]  s_ra_data, s_rb_data, s_dbg0, s_dbg1, s_dbg2;

    regfile_sync u_dut (
        .clk(clk), .rst(rst),
        .ra_en(ra_en), .ra_addr(ra_addr),
        .rb_en(rb_en), .rb_addr(rb_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy),
        .ra_data(ra_data), .ra_valid(ra_valid),
        .rb_data(rb_data), .rb_valid(rb_valid),
        .dbg0(dbg0), .dbg1(dbg1), .dbg2(dbg2)
    );

    regfile_sync #(.DATA_W(8), .DEPTH(12)) u_dut12 (
        .clk(clk), .rst(s_rst),
        .ra_en(s_ra_en), .ra_addr(s_ra_addr),
        .rb_en(s_rb_en), .rb_addr(s_rb_addr),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .clr_req(s_clr_req), .busy(s_busy),
        .ra_data(s_ra_data), .ra_valid(s_ra_valid),
        .rb_data(s_rb_data), .rb_valid(s_rb_valid),
        .dbg0(s_dbg0), .dbg1(s_dbg1), .dbg2(s_dbg2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model, one slot per instance
    logic [31:0] mm [2][16];
    int          left [2];
    logic [31:0] m_rd [2], m_bd [2];
    bit          m_rv [2], m_bv [2];
    bit          known [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int d, input bit r, input bit cr,
                        input bit we, input logic [3:0] wa, input logic [31:0] wd,
                        input bit ae, input logic [3:0] aa,
                        input bit be, input logic [3:0] ba);
        int          dep = (d != 0) ? 12 : 16;
        logic [31:0] wdm = (d != 0) ? (wd & 32'hFF) : wd;
        logic [31:0] g_rd, g_bd, g0, g1, g2;
        logic        g_busy, g_rv, g_bv;
        @(negedge clk);
        if (d == 0) begin
            rst = r; clr_req = cr; wr_en = we; wr_addr = wa; wr_data = wd;
            ra_en = ae; ra_addr = aa; rb_en = be; rb_addr = ba;
        end else begin
            s_rst = r; s_clr_req = cr; s_wr_en = we; s_wr_addr = wa; s_wr_data = wd[7:0];
            s_ra_en = ae; s_ra_addr = aa; s_rb_en = be; s_rb_addr = ba;
        end
        @(posedge clk);
        if (r) begin
            left[d] = dep;
            m_rd[d] = 0; m_bd[d] = 0; m_rv[d] = 0; m_bv[d] = 0;
        end else if (left[d] > 0) begin
            mm[d][dep-left[d]] = 0;
            left[d]--;
            if (left[d] == 0) known[d] = 1;
            m_rv[d] = 0; m_bv[d] = 0;
        end else if (cr) begin
            left[d] = dep;
            m_rv[d] = 0; m_bv[d] = 0;
        end else begin
            m_rv[d] = ae;
            m_bv[d] = be;
            if (ae) m_rd[d] = (int'(aa) < dep) ? mm[d][aa] : 0;
            if (be) m_bd[d] = (int'(ba) < dep) ? mm[d][ba] : 0;
`ifdef REGFILE_BYPASS_EN
            if (ae && we && wa == aa && int'(aa) < dep) m_rd[d] = wdm;
            if (be && we && wa == ba && int'(ba) < dep) m_bd[d] = wdm;
`endif
            if (we && int'(wa) < dep) mm[d][wa] = wdm;
        end
        #1;
        if (d == 0) begin
            g_busy = busy; g_rv = ra_valid; g_bv = rb_valid;
            g_rd = ra_data; g_bd = rb_data; g0 = dbg0; g1 = dbg1; g2 = dbg2;
        end else begin
            g_busy = s_busy; g_rv = s_ra_valid; g_bv = s_rb_valid;
            g_rd = {24'b0, s_ra_data}; g_bd = {24'b0, s_rb_data};
            g0 = {24'b0, s_dbg0}; g1 = {24'b0, s_dbg1}; g2 = {24'b0, s_dbg2};
        end
        check($sformatf("d%0d busy", d), {31'b0, g_busy}, {31'b0, left[d] > 0});
        check($sformatf("d%0d ra_valid", d), {31'b0, g_rv}, {31'b0, m_rv[d]});
        check($sformatf("d%0d rb_valid", d), {31'b0, g_bv}, {31'b0, m_bv[d]});
        check($sformatf("d%0d ra_data", d), g_rd, m_rd[d]);
        check($sformatf("d%0d rb_data", d), g_bd, m_bd[d]);
        if (known[d]) begin
            check($sformatf("d%0d dbg0", d), g0, mm[d][1]);
            check($sformatf("d%0d dbg1", d), g1, mm[d][2]);
            check($sformatf("d%0d dbg2", d), g2, mm[d][3]);
        end
    endtask

    task automatic idle(input int d);
        step(d, 0, 0, 0, 4'd0, 32'd0, 0, 4'd0, 0, 4'd0);
    endtask

    task automatic rd2(input int d, input logic [3:0] a, input logic [3:0] b);
        step(d, 0, 0, 0, 4'd0, 32'd0, 1, a, 1, b);
    endtask

    task automatic wr(input int d, input logic [3:0] a, input logic [31:0] v);
        step(d, 0, 0, 1, a, v, 0, 4'd0, 0, 4'd0);
    endtask

    task automatic rnd(input int d, input int n, input int rst_mod, input int clr_mod);
        for (int i = 0; i < n; i++) begin
            step(d, ($urandom % rst_mod) == 0, ($urandom % clr_mod) == 0,
                 $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
                 $urandom_range(0, 1) == 1, 4'($urandom),
                 $urandom_range(0, 1) == 1, 4'($urandom));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            left[d] = 0; known[d] = 0;
            m_rd[d] = 0; m_bd[d] = 0; m_rv[d] = 0; m_bv[d] = 0;
            for (int k = 0; k < 16; k++) mm[d][k] = 0;
        end

        // reset and full sweep, then every address reads zero
        repeat (2) step(0, 1, 0, 0, 4'd0, 32'd0, 0, 4'd0, 0, 4'd0);
        repeat (16) idle(0);
        for (int i = 0; i < 16; i++) rd2(0, 4'(i), 4'(15 - i));
        idle(0);

        // write then dual read of same address, then hold
        wr(0, 4'd5, 32'hDEADBEEF);
        rd2(0, 4'd5, 4'd5);
        idle(0);

        // read/write collision
        wr(0, 4'd7, 32'h11);
        step(0, 0, 0, 1, 4'd7, 32'h22, 1, 4'd7, 1, 4'd7);
        rd2(0, 4'd7, 4'd7);

        // clear mid-traffic; accesses during the sweep are ignored
        for (int i = 1; i <= 3; i++) wr(0, 4'(i), 32'hA5);
        step(0, 0, 1, 1, 4'd4, 32'h77, 1, 4'd1, 1, 4'd2);
        rnd(0, 16, 1000000, 1000000);
        for (int i = 1; i <= 4; i++) rd2(0, 4'(i), 4'(i));

        // reset at clear cycle 8, then a redundant clr_req during the sweep
        for (int i = 0; i < 16; i++) wr(0, 4'(i), 32'hC0DE0000 + i);
        step(0, 0, 1, 0, 4'd0, 32'd0, 0, 4'd0, 0, 4'd0);
        repeat (7) idle(0);
        step(0, 1, 0, 0, 4'd0, 32'd0, 0, 4'd0, 0, 4'd0);
        repeat (5) idle(0);
        step(0, 0, 1, 0, 4'd0, 32'd0, 0, 4'd0, 0, 4'd0);
        repeat (11) idle(0);
        for (int i = 0; i < 16; i++) rd2(0, 4'(i), 4'(i));

        rnd(0, 600, 150, 40);

        // 8x12 instance: out-of-range address behaviour
        rst = 1'b0;
        repeat (2) step(1, 1, 0, 0, 4'd0, 32'd0, 0, 4'd0, 0, 4'd0);
        repeat (12) idle(1);
        rd2(1, 4'd13, 4'd13);
        for (int i = 0; i < 12; i++) wr(1, 4'(i), 32'h10 + i);
        wr(1, 4'd13, 32'hEE);
        for (int i = 0; i < 12; i++) rd2(1, 4'(i), 4'(11 - i));
        rnd(1, 300, 150, 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
